dmem_align_unit: RTL and testbench
==================================

# dmem_align_unit

Byte-addressed load/store access unit that sits between the CPU's memory-control stage and a 32-bit word-organised synchronous data SRAM. It accepts byte, halfword and word requests at any byte address. Requests that straddle a word boundary are split into two aligned word accesses with byte enables. A busy signal stalls the requester until the access completes. Read data is returned raw and zero-extended; sign extension remains in the CPU.

## Interface
- ADDR_WIDTH, 12: byte-address width; the word index is ADDR_WIDTH-2 bits (1024 words).
- clk  in  1  system clock, rising edge
- reset_b  in  1  reset, asynchronous, active-low
- req_rd  in  1  load request; sampled only in IDLE
- req_wr  in  1  store request; sampled only in IDLE; has priority when both are high
- req_sz  in  2  size: 00 byte, 01 half, 10 word, 11 treated as word
- req_addr  in  ADDR_WIDTH  byte address
- req_din  in  32  store data, right-aligned; only the low size bytes are used
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a transaction completes
- resp_dout  out  32  load result, right-aligned, zero-extended; holds until the next load completes
- split_count  out  16  saturating count of boundary-crossing accesses
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_be  out  4  byte-lane enables; lane i is bits [8i+7:8i]
- mem_addr  out  ADDR_WIDTH-2  word index
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data; valid the cycle after a read is issued (1-cycle latency)

## Operation

**Request latch and derived fields**
- In IDLE, a rising edge with req_rd or req_wr high latches addr, sz and din.
- Derived fields:
  - off = addr[1:0]
  - W = addr >> 2
  - nbytes = 1, 2 or 4
  - cross = (off + nbytes > 4)
  - mask8 = ((1<<nbytes)-1) << off
  - data64 = {32'b0, din} << 8*off
- W+1 wraps modulo 2^(ADDR_WIDTH-2).

**State machine** (states IDLE, RD_LO, RD_HI, RD_FIN, WR_LO, WR_HI)
- IDLE: all mem_* outputs are 0. A request moves to WR_LO if req_wr is high, else to RD_LO.
- RD_LO: mem_en=1, mem_we=0, mem_addr=W, mem_be=1111. Next state is RD_HI if cross, else RD_FIN.
- RD_HI: mem_en=1, mem_addr=W+1. mem_rdata (word W) is captured into lo_q. Next state is RD_FIN.
- RD_FIN: mem_en=0.
  - On the edge: resp_dout <= ({hi, lo} >> 8*off), masked to nbytes.
    - If cross: lo=lo_q, hi=mem_rdata.
    - Else: lo=mem_rdata.
  - done <= 1; go to IDLE.
- WR_LO: mem_en=1, mem_we=1, mem_addr=W, mem_be=mask8[3:0], mem_wdata=data64[31:0].
  - Next state is WR_HI if cross.
  - Otherwise done <= 1 and go to IDLE.
- WR_HI: mem_addr=W+1, mem_be=mask8[7:4], mem_wdata=data64[63:32]. done <= 1; go to IDLE.

**split_count**
- Increments once per accepted crossing request, on the acceptance edge.
- Saturates at 0xFFFF.

**Request handling while busy**
- Requests while busy are ignored, not queued.
- The done cycle is an IDLE cycle. A request still held then is accepted as a new transaction, so the requester must drop req on done unless it intends a new access.

## Timing
- Acceptance edge = edge 0.
- Aligned load: RD_LO in cycle 1, RD_FIN in cycle 2; done and resp_dout valid in cycle 3.
- Crossing load: done and resp_dout valid in cycle 4.
- Aligned store: SRAM write in cycle 1; done in cycle 2.
- Crossing store: writes in cycles 1 and 2; done in cycle 3.
- Back-to-back: a new request may be accepted in the done cycle.
- Reset values:
  - state = IDLE
  - busy, done, mem_en, mem_we = 0
  - mem_be, mem_addr, mem_wdata = 0
  - resp_dout = 0, split_count = 0, lo_q = 0
- Reset mid-operation: returns to IDLE immediately and no done is issued. For a crossing store, the low word may already be written while the high word is not; this is accepted behaviour.

## Test plan
Preload SRAM with word0=0x44332211, word1=0x88776655, word1023=0xDDCCBBAA.
- Word load at byte address 0x000, sz=10 -> one read of W=0; done in cycle 3; resp_dout=0x44332211; split_count=0.
- Half load at 0x003 -> reads W=0 then W=1; done in cycle 4; resp_dout=0x00005544; split_count=1.
- Word store of 0xAABBCCDD at 0x002 -> WR_LO writes be=1100, wdata=0xCCDD0000 to W=0; WR_HI writes be=0011, wdata=0x0000AABB to W=1; done in cycle 3; word0=0xCCDD2211, word1=0x8877AABB.
- Wrap: word load at 0xFFE -> mem_addr 1023 then 0; resp_dout=0x2211DDCC. Byte load at 0x005 -> resp_dout=0x00000066, no split.
- Reset asserted during WR_HI of a crossing store -> all outputs 0 at once, no done pulse, state IDLE. A subsequent aligned load completes normally.
- req_rd pulsed in cycles 1-2 of an active load is ignored (one done, one transaction). With req_rd and req_wr both high in IDLE, the store is executed.

Source files
------------

// File: rtl/dmem_align_unit_if.sv
// dmem_align_unit_if
//   Request/response bus between the CPU memory-control stage and the
//   load/store alignment unit.
//   req_rd, req_wr : load / store request (store wins when both are high)
//   req_sz         : 00 byte, 01 half, 10/11 word
//   req_addr       : byte address
//   req_din        : store data, right-aligned
//   busy           : unit is working on a transaction
//   done           : one-cycle completion pulse
//   resp_dout      : load result, right-aligned and zero-extended
//   Modports: master = requester (CPU side), slave = alignment unit.
interface dmem_align_unit_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  req_rd;
    logic                  req_wr;
    logic [1:0]            req_sz;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_din;
    logic                  busy;
    logic                  done;
    logic [31:0]           resp_dout;

    modport master (
        output req_rd, req_wr, req_sz, req_addr, req_din,
        input  busy, done, resp_dout
    );

    modport slave (
        input  req_rd, req_wr, req_sz, req_addr, req_din,
        output busy, done, resp_dout
    );
endinterface

// File: rtl/dmem_align_unit.sv
// dmem_align_unit
//   Byte-addressed load/store unit in front of a 32-bit word SRAM with
//   1-cycle read latency. Accesses that straddle a word boundary become two
//   aligned word accesses; the unit is busy until the access completes.
//   Ports:
//     clk, reset_b   : clock, asynchronous active-low reset
//     bus (slave)    : request/response bus (see dmem_align_unit_if)
//     split_count    : saturating count of accepted boundary-crossing requests
//     mem_en/mem_we  : SRAM enable / write enable
//     mem_be         : byte-lane enables, lane i = bits [8i+7:8i]
//     mem_addr       : SRAM word index
//     mem_wdata      : SRAM write data
//     mem_rdata      : SRAM read data, valid the cycle after the read
module dmem_align_unit #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_b,
    dmem_align_unit_if.slave      bus,
    output logic [15:0]           split_count,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    localparam int WW = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, RD_FIN, WR_LO, WR_HI
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            sz_q;
    logic [31:0]           din_q;
    logic [31:0]           lo_q;
    logic [31:0]           resp_q;
    logic                  done_q;
    logic [15:0]           split_q;
    logic                  done_set;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
        logic [3:0] last;
        last = {2'b00, off} + {1'b0, size_bytes(sz)};
        return last > 4'd4;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [1:0] sz);
        case (sz)
            2'b00:   return 8'h01 << off;
            2'b01:   return 8'h03 << off;
            default: return 8'h0F << off;
        endcase
    endfunction

    // Shift the two-word window down to the addressed byte, then keep only
    // the requested size so the result is zero-extended.
    function automatic logic [31:0] extract(input logic [63:0] pair,
                                            input logic [1:0]  off,
                                            input logic [1:0]  sz);
        logic [63:0] sh;
        sh = pair >> {off, 3'b000};
        case (sz)
            2'b00:   return {24'h0, sh[7:0]};
            2'b01:   return {16'h0, sh[15:0]};
            default: return sh[31:0];
        endcase
    endfunction

    logic [1:0]  off_q;
    logic [WW-1:0] w_q;
    logic [WW-1:0] w_nxt;
    logic        cross_q;
    logic [7:0]  mask_q;
    logic [63:0] data64_q;
    logic [63:0] rd_pair;
    logic        accept;
    logic        cross_in;

    assign off_q    = addr_q[1:0];
    assign w_q      = addr_q[ADDR_WIDTH-1:2];
    assign w_nxt    = w_q + WW'(1);          // wraps at the top of the SRAM
    assign cross_q  = crosses(off_q, sz_q);
    assign mask_q   = lane_mask(off_q, sz_q);
    assign data64_q = {32'h0, din_q} << {off_q, 3'b000};
    // lo_q holds word W when the load crossed; otherwise only mem_rdata matters
    assign rd_pair  = cross_q ? {mem_rdata, lo_q} : {32'h0, mem_rdata};

    assign accept   = (state == IDLE) && (bus.req_rd || bus.req_wr);
    assign cross_in = crosses(bus.req_addr[1:0], bus.req_sz);

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.resp_dout = resp_q;
    assign split_count   = split_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        case (state)
            IDLE: begin
                if (bus.req_wr) begin
                    state_nxt = WR_LO;
                end else if (bus.req_rd) begin
                    state_nxt = RD_LO;
                end
            end
            RD_LO: begin
                mem_en    = 1'b1;
                mem_be    = 4'hF;
                mem_addr  = w_q;
                state_nxt = cross_q ? RD_HI : RD_FIN;
            end
            RD_HI: begin
                mem_en    = 1'b1;
                mem_be    = 4'hF;
                mem_addr  = w_nxt;
                state_nxt = RD_FIN;
            end
            RD_FIN: begin
                done_set  = 1'b1;
                state_nxt = IDLE;
            end
            WR_LO: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_be    = mask_q[3:0];
                mem_addr  = w_q;
                mem_wdata = data64_q[31:0];
                if (cross_q) begin
                    state_nxt = WR_HI;
                end else begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_HI: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_be    = mask_q[7:4];
                mem_addr  = w_nxt;
                mem_wdata = data64_q[63:32];
                done_set  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            addr_q  <= '0;
            sz_q    <= 2'b00;
            din_q   <= 32'h0;
            lo_q    <= 32'h0;
            resp_q  <= 32'h0;
            done_q  <= 1'b0;
            split_q <= 16'h0;
        end else begin
            done_q <= done_set;
            if (accept) begin
                addr_q <= bus.req_addr;
                sz_q   <= bus.req_sz;
                din_q  <= bus.req_din;
                if (cross_in && (split_q != 16'hFFFF)) begin
                    split_q <= split_q + 16'd1;
                end
            end
            if (state == RD_HI) begin
                lo_q <= mem_rdata;
            end
            if (state == RD_FIN) begin
                resp_q <= extract(rd_pair, off_q, sz_q);
            end
        end
    end
endmodule

// File: tb/tb_dmem_align_unit.sv
// tb_dmem_align_unit
//   Directed bench for dmem_align_unit with a behavioural 1024-word SRAM
//   (1-cycle read latency). Each scenario task drives requests and checks
//   SRAM traffic, done timing and results against hand-computed values.
module tb_dmem_align_unit;
    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        preload;
    logic [15:0] split_count;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] sram [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_align_unit_if #(.ADDR_WIDTH(AW)) u_if ();

    dmem_align_unit #(.ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .bus         (u_if),
        .split_count (split_count),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
            sram[0]    <= 32'h44332211;
            sram[1]    <= 32'h88776655;
            sram[1023] <= 32'hDDCCBBAA;
            mem_rdata  <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request now, let it be accepted on the next edge, then drop it.
    // Returns during cycle 1 of the transaction.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [11:0] addr, input logic [31:0] din);
        u_if.req_rd   = rd;
        u_if.req_wr   = wr;
        u_if.req_sz   = sz;
        u_if.req_addr = addr;
        u_if.req_din  = din;
        step();
        u_if.req_rd = 1'b0;
        u_if.req_wr = 1'b0;
    endtask

    // Bounded wait for done; cyc is the cycle number it appeared in, or -1.
    task automatic wait_done(input int start, output int cyc);
        cyc = -1;
        for (int k = start; k < start + 12; k++) begin
            if (u_if.done === 1'b1) begin
                cyc = k;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        preload = 1'b1;
        u_if.req_rd = 1'b0; u_if.req_wr = 1'b0; u_if.req_sz = 2'b00;
        u_if.req_addr = 12'h0; u_if.req_din = 32'h0;
        #1;
        n_tests++;
        if ({u_if.busy, u_if.done, mem_en, mem_we} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl got %b exp 0000", {u_if.busy, u_if.done, mem_en, mem_we});
        end
        step(); step();
        preload = 1'b0;
        n_tests++;
        if ({mem_be, mem_addr, mem_wdata} !== 46'h0) begin
            n_fail++; $display("FAIL reset_mem got be=%h addr=%h wdata=%h exp 0", mem_be, mem_addr, mem_wdata);
        end
        n_tests++;
        if ({u_if.resp_dout, split_count} !== 48'h0) begin
            n_fail++; $display("FAIL reset_data got resp=%h split=%h exp 0", u_if.resp_dout, split_count);
        end
        reset_b = 1'b1;
        step();
    endtask

    task automatic test_word_load();
        int cyc;
        issue(1'b1, 1'b0, 2'b10, 12'h000, 32'h0);
        n_tests++;
        if ({u_if.busy, mem_en, mem_we, mem_be, mem_addr} !== {1'b1, 1'b1, 1'b0, 4'hF, 10'd0}) begin
            n_fail++; $display("FAIL word_load_rd got busy=%b en=%b we=%b be=%h addr=%0d exp 1 1 0 f 0",
                               u_if.busy, mem_en, mem_we, mem_be, mem_addr);
        end
        wait_done(1, cyc);
        n_tests++;
        if (cyc !== 3) begin n_fail++; $display("FAIL word_load_cycle got %0d exp 3", cyc); end
        n_tests++;
        if (u_if.resp_dout !== 32'h44332211 || split_count !== 16'd0) begin
            n_fail++; $display("FAIL word_load_resp got %h split %0d exp 44332211 split 0", u_if.resp_dout, split_count);
        end
    endtask

    task automatic test_cross_load();
        int cyc;
        issue(1'b1, 1'b0, 2'b01, 12'h003, 32'h0);
        n_tests++;
        if ({mem_en, mem_addr} !== {1'b1, 10'd0}) begin
            n_fail++; $display("FAIL half_cross_lo got en=%b addr=%0d exp 1 0", mem_en, mem_addr);
        end
        step();
        n_tests++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd1}) begin
            n_fail++; $display("FAIL half_cross_hi got en=%b we=%b addr=%0d exp 1 0 1", mem_en, mem_we, mem_addr);
        end
        wait_done(2, cyc);
        n_tests++;
        if (cyc !== 4) begin n_fail++; $display("FAIL half_cross_cycle got %0d exp 4", cyc); end
        n_tests++;
        if (u_if.resp_dout !== 32'h00005544 || split_count !== 16'd1) begin
            n_fail++; $display("FAIL half_cross_resp got %h split %0d exp 00005544 split 1", u_if.resp_dout, split_count);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        issue(1'b1, 1'b0, 2'b10, 12'hFFE, 32'h0);
        n_tests++;
        if (mem_addr !== 10'd1023) begin n_fail++; $display("FAIL wrap_lo_addr got %0d exp 1023", mem_addr); end
        step();
        n_tests++;
        if ({mem_en, mem_addr} !== {1'b1, 10'd0}) begin
            n_fail++; $display("FAIL wrap_hi_addr got en=%b addr=%0d exp 1 0", mem_en, mem_addr);
        end
        wait_done(2, cyc);
        n_tests++;
        if (cyc !== 4 || u_if.resp_dout !== 32'h2211DDCC) begin
            n_fail++; $display("FAIL wrap_resp got cyc %0d resp %h exp cyc 4 resp 2211ddcc", cyc, u_if.resp_dout);
        end
        issue(1'b1, 1'b0, 2'b00, 12'h005, 32'h0);
        n_tests++;
        if (mem_addr !== 10'd1) begin n_fail++; $display("FAIL byte_load_addr got %0d exp 1", mem_addr); end
        wait_done(1, cyc);
        n_tests++;
        if (cyc !== 3 || u_if.resp_dout !== 32'h00000066 || split_count !== 16'd2) begin
            n_fail++; $display("FAIL byte_load got cyc %0d resp %h split %0d exp 3 00000066 2",
                               cyc, u_if.resp_dout, split_count);
        end
    endtask

    task automatic test_cross_store();
        int cyc;
        issue(1'b0, 1'b1, 2'b10, 12'h002, 32'hAABBCCDD);
        n_tests++;
        if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1100, 10'd0, 32'hCCDD0000}) begin
            n_fail++; $display("FAIL store_lo got en=%b we=%b be=%b addr=%0d wdata=%h exp 1 1 1100 0 ccdd0000",
                               mem_en, mem_we, mem_be, mem_addr, mem_wdata);
        end
        step();
        n_tests++;
        if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 10'd1, 32'h0000AABB}) begin
            n_fail++; $display("FAIL store_hi got en=%b we=%b be=%b addr=%0d wdata=%h exp 1 1 0011 1 0000aabb",
                               mem_en, mem_we, mem_be, mem_addr, mem_wdata);
        end
        wait_done(2, cyc);
        n_tests++;
        if (cyc !== 3) begin n_fail++; $display("FAIL store_cycle got %0d exp 3", cyc); end
        n_tests++;
        if (sram[0] !== 32'hCCDD2211 || sram[1] !== 32'h8877AABB) begin
            n_fail++; $display("FAIL store_sram got w0=%h w1=%h exp ccdd2211 8877aabb", sram[0], sram[1]);
        end
        n_tests++;
        if (u_if.resp_dout !== 32'h00000066 || split_count !== 16'd3) begin
            n_fail++; $display("FAIL store_side got resp %h split %0d exp 00000066 3", u_if.resp_dout, split_count);
        end
        // back-to-back: issue in the done cycle
        issue(1'b1, 1'b0, 2'b10, 12'h000, 32'h0);
        wait_done(1, cyc);
        n_tests++;
        if (cyc !== 3 || u_if.resp_dout !== 32'hCCDD2211) begin
            n_fail++; $display("FAIL readback got cyc %0d resp %h exp 3 ccdd2211", cyc, u_if.resp_dout);
        end
        step();
    endtask

    task automatic test_ignore_busy();
        int n_done;
        issue(1'b1, 1'b0, 2'b10, 12'h004, 32'h0);
        u_if.req_rd = 1'b1; u_if.req_sz = 2'b00; u_if.req_addr = 12'h000;
        step();
        step();
        u_if.req_rd = 1'b0;
        n_done = 0;
        n_tests++;
        if (u_if.resp_dout !== 32'h8877AABB) begin
            n_fail++; $display("FAIL busy_ignore_resp got %h exp 8877aabb", u_if.resp_dout);
        end
        for (int k = 0; k < 6; k++) begin
            if (u_if.done === 1'b1) n_done++;
            step();
        end
        n_tests++;
        if (n_done !== 1 || u_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_ignore_count got dones %0d busy %b exp 1 0", n_done, u_if.busy);
        end
    endtask

    task automatic test_both_high();
        int cyc;
        issue(1'b1, 1'b1, 2'b00, 12'h001, 32'h000000EE);
        n_tests++;
        if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0010, 10'd0, 32'h0000EE00}) begin
            n_fail++; $display("FAIL both_high_wr got en=%b we=%b be=%b addr=%0d wdata=%h exp 1 1 0010 0 0000ee00",
                               mem_en, mem_we, mem_be, mem_addr, mem_wdata);
        end
        wait_done(1, cyc);
        n_tests++;
        if (cyc !== 2 || u_if.resp_dout !== 32'h8877AABB) begin
            n_fail++; $display("FAIL both_high_done got cyc %0d resp %h exp 2 8877aabb", cyc, u_if.resp_dout);
        end
        step();
        n_tests++;
        if (sram[0] !== 32'hCCDDEE11) begin n_fail++; $display("FAIL both_high_sram got %h exp ccddee11", sram[0]); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        issue(1'b0, 1'b1, 2'b10, 12'h00A, 32'h12345678);
        step();
        n_tests++;
        if ({mem_be, mem_addr, split_count} !== {4'b0011, 10'd3, 16'd4}) begin
            n_fail++; $display("FAIL midrst_pre got be=%b addr=%0d split=%0d exp 0011 3 4", mem_be, mem_addr, split_count);
        end
        #1 reset_b = 1'b0;
        #1;
        n_tests++;
        if ({u_if.busy, u_if.done, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== 50'h0) begin
            n_fail++; $display("FAIL midrst_out got busy=%b done=%b en=%b we=%b be=%b addr=%0d wdata=%h exp 0",
                               u_if.busy, u_if.done, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
        end
        n_tests++;
        if ({u_if.resp_dout, split_count} !== 48'h0) begin
            n_fail++; $display("FAIL midrst_data got resp=%h split=%h exp 0", u_if.resp_dout, split_count);
        end
        step();
        reset_b = 1'b1;
        step();
        n_tests++;
        if ({u_if.done, u_if.busy} !== 2'b00 || sram[2] !== 32'h56780000 || sram[3] !== 32'h0) begin
            n_fail++; $display("FAIL midrst_after got done=%b busy=%b w2=%h w3=%h exp 0 0 56780000 0",
                               u_if.done, u_if.busy, sram[2], sram[3]);
        end
        issue(1'b1, 1'b0, 2'b10, 12'h008, 32'h0);
        wait_done(1, cyc);
        n_tests++;
        if (cyc !== 3 || u_if.resp_dout !== 32'h56780000) begin
            n_fail++; $display("FAIL postrst_load got cyc %0d resp %h exp 3 56780000", cyc, u_if.resp_dout);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_cross_load();
        test_wrap();
        test_cross_store();
        test_ignore_busy();
        test_both_high();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
